// File: rtl/truth_table_scanner.sv
// Sweeps the 16 input combinations of a 4-input function stage, samples F after a
// programmable settle time, and reports the captured truth table against a reference.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    // Named table_o because 'table' is a reserved word in SystemVerilog.
    output logic [15:0] table_o,
    output logic [4:0]  ones_count,
    output logic        mismatch,
    output logic [15:0] mismatch_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  ones_q, ones_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            table_q <= 16'h0000;
            ones_q  <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = WAIT;
                    idx_d   = 4'd0;
                    cnt_d   = SETTLE_C;
                    table_d = 16'h0000;
                    ones_d  = 5'd0;
                    valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    table_d[idx_q] = f_in;
                    ones_d         = ones_q + 5'(f_in);
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = SETTLE_C;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            cnt_d   = 4'd0;
            table_d = 16'h0000;
            ones_d  = 5'd0;
            valid_d = 1'b0;
        end
    end

    assign busy          = (state_q == WAIT);
    assign done          = (state_q == DONE);
    assign {a, b, c, d}  = busy ? idx_q : 4'd0;
    assign valid         = valid_q;
    assign table_o       = table_q;
    assign ones_count    = ones_q;
    assign mismatch      = valid_q && (table_q != EXPECTED);
    assign mismatch_mask = valid_q ? (table_q ^ EXPECTED) : 16'h0000;

endmodule
